// File: rtl/load_store_unit_pkg.sv
// Shared encodings, FSM state type and access helpers for the load/store unit.
package lsu_pkg;

  // Store width codes, matching the main decoder
  localparam logic [1:0] ST_SB = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SW = 2'b10;

  // Load width/sign codes, matching the main decoder
  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;

  typedef enum logic [1:0] {IDLE, REQ, DONE} lsu_state_t;

  // Natural alignment: halves need bit 0 clear, words need both low bits clear.
  // Unused store/load codes fall back to word size.
  function automatic logic is_aligned(input logic we, input logic [1:0] st,
                                      input logic [2:0] ld, input logic [1:0] off);
    logic ok;
    if (we) begin
      case (st)
        ST_SB:   ok = 1'b1;
        ST_SH:   ok = ~off[0];
        default: ok = (off == 2'b00);
      endcase
    end else begin
      case (ld)
        LD_LB, LD_LBU: ok = 1'b1;
        LD_LH, LD_LHU: ok = ~off[0];
        default:       ok = (off == 2'b00);
      endcase
    end
    return ok;
  endfunction

  // Byte enables for a store at the given word offset
  function automatic logic [3:0] store_be(input logic [1:0] st, input logic [1:0] off);
    logic [3:0] be;
    case (st)
      ST_SB:   be = 4'b0001 << off;
      ST_SH:   be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data replicated across lanes so the enabled lanes see the right bytes
  function automatic logic [31:0] store_wdata(input logic [1:0] st, input logic [31:0] wd);
    logic [31:0] d;
    case (st)
      ST_SB:   d = {4{wd[7:0]}};
      ST_SH:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Valid/ready data bus between the load/store unit and memory.
interface load_store_unit_if #(parameter int ADDR_W = 32) ();
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_be;
  logic [31:0]       bus_wdata;
  logic              bus_ready;
  logic [31:0]       bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/load_store_unit_load_extend.sv
// Picks the addressed byte/half out of a read word and sign- or zero-extends it.
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  load,
  input  logic [1:0]  offset,
  output logic [31:0] data
);

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign shifted = rdata >> {offset, 3'b000};
  assign byte_v  = shifted[7:0];
  assign half_v  = offset[1] ? rdata[31:16] : rdata[15:0];

  // Extension by load code; unused codes read the full word
  always_comb begin
    data = rdata;
    case (load)
      LD_LB:   data = {{24{byte_v[7]}}, byte_v};
      LD_LBU:  data = {24'h0, byte_v};
      LD_LH:   data = {{16{half_v[15]}}, half_v};
      LD_LHU:  data = {16'h0, half_v};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Turns single-cycle core loads/stores into word-aligned byte-enabled bus
// requests, stalling the core until the bus completes or times out.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        Store,
  input  logic [2:0]        Load,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       WriteData,
  output logic [31:0]       ReadData,
  output logic              Stall,
  output logic              Misaligned,
  output logic              BusErr,
  load_store_unit_if.master bus
);

  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  lsu_state_t        state;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              we_q;
  logic              err_q;
  logic [2:0]        ld_q;
  logic [1:0]        off_q;
  logic [31:0]       cnt_q;

  logic        op_valid;
  logic        aligned;
  logic        start;
  logic        in_req;
  logic        to_hit;
  logic [31:0] ext_data;

  assign op_valid = MemRead | MemWrite;
  // MemWrite wins when both strobes are high
  assign aligned  = is_aligned(MemWrite, Store, Load, Addr[1:0]);
  // Gated by reset so nothing leaks out combinationally while held in reset
  assign start    = reset & (state == IDLE) & op_valid & aligned;
  assign in_req   = (state == REQ);
  assign to_hit   = TO_EN && (cnt_q == TO_LAST);

  // Access FSM: capture in IDLE, hold bus in REQ, present result in DONE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      ld_q    <= '0;
      off_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addr_q  <= {Addr[ADDR_W-1:2], 2'b00};
            we_q    <= MemWrite;
            be_q    <= MemWrite ? store_be(Store, Addr[1:0]) : 4'b1111;
            wdata_q <= MemWrite ? store_wdata(Store, WriteData) : 32'h0;
            ld_q    <= Load;
            off_q   <= Addr[1:0];
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            state   <= REQ;
          end
        end
        REQ: begin
          if (bus.bus_ready) begin
            rdata_q <= bus.bus_rdata;
            state   <= DONE;
          end else if (to_hit) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
            state   <= DONE;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  load_extend u_ext (
    .rdata  (rdata_q),
    .load   (ld_q),
    .offset (off_q),
    .data   (ext_data)
  );

  // Bus outputs come straight from captured registers, qualified by REQ
  assign bus.bus_req   = in_req;
  assign bus.bus_we    = in_req & we_q;
  assign bus.bus_addr  = in_req ? addr_q : '0;
  assign bus.bus_be    = in_req ? be_q : 4'b0000;
  assign bus.bus_wdata = in_req ? wdata_q : 32'h0;

  assign Stall      = start | in_req;
  assign Misaligned = reset & (state == IDLE) & op_valid & ~aligned;
  assign BusErr     = (state == DONE) & err_q;
  assign ReadData   = ((state == DONE) && !err_q) ? ext_data : 32'h0;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Downstream consumer of the main decoder's memory controls: MemWrite, Store[1:0], Load[2:0], plus a load strobe derived from ResultSrc==01.
- Converts each load or store into a word-aligned, byte-enabled request on a valid/ready data bus.
- Stalls the single-cycle core until the bus completes.
- Returns sign- or zero-extended load data to the result mux.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in REQ without bus_ready before abort; 0 disables the timeout
ADDR_W, 32, address width

Ports:
clk  input  1  core clock
reset  input  1  asynchronous, active-low reset
MemRead  input  1  load in current instruction (ResultSrc==01)
MemWrite  input  1  store in current instruction
Store  input  2  00 sb, 01 sh, 10 sw
Load  input  3  000 lb, 001 lh, 010 lw, 011 lbu, 100 lhu
Addr  input  ADDR_W  ALU-computed byte address
WriteData  input  32  rs2 value
ReadData  output  32  extended load result, valid in DONE
Stall  output  1  hold PC/regfile write while high
Misaligned  output  1  one-cycle flag for a rejected misaligned access
BusErr  output  1  one-cycle flag in DONE after a timeout
bus_req  output  1  request valid
bus_we  output  1  1 write, 0 read
bus_addr  output  ADDR_W  {Addr[ADDR_W-1:2],2'b00}
bus_be  output  4  byte enables
bus_wdata  output  32  lane-replicated store data
bus_ready  input  1  completion, same cycle as bus_rdata
bus_rdata  input  32  read word

Behaviour:
- Reset (async, low):
  - FSM goes to IDLE; all registers and the timeout counter clear.
  - bus_req, bus_we, bus_be, bus_addr, bus_wdata, ReadData, Misaligned, BusErr and Stall are all 0.
  - bus_req drops immediately, even mid-REQ; the aborted transaction is never completed.
- Op valid = MemRead|MemWrite. If both are high, the access is a write and MemRead is ignored.
- Alignment check: sh/lh/lhu require Addr[0]==0; sw/lw require Addr[1:0]==00.
- IDLE:
  - Valid aligned op: capture word address, be, wdata, we, Load code and Addr[1:0] into registers. Stall=1 (combinational). Next state REQ.
  - Valid misaligned op: Misaligned=1, Stall=0, ReadData=0, no bus activity, no state change.
  - No op: Stall=0.
- REQ:
  - bus_req=1; all bus outputs come from the registers captured in IDLE and stay stable until bus_ready. Stall=1.
  - bus_ready=1: capture bus_rdata, go to DONE.
  - Timeout: counter increments each REQ cycle. When it reaches TIMEOUT_CYCLES (nonzero) without bus_ready, drop bus_req, set the error flag, go to DONE.
- DONE:
  - Stall=0; ReadData holds the extended captured data (0 on timeout); BusErr=1 if timed out.
  - Next state IDLE unconditionally. The core advances at the end of DONE.
- bus_ready outside REQ is ignored.
- Minimum access is 3 cycles (IDLE, REQ with immediate ready, DONE), i.e. 2 stall cycles.
- Byte enables:
  - sb: be = 1<<Addr[1:0]; wdata = byte replicated on all 4 lanes.
  - sh: be = 0011 (Addr[1]=0) or 1100; wdata = halfword replicated twice.
  - sw: be = 1111.
  - Store 11 is treated as sw.
  - Reads always drive be = 1111.
- Load extraction uses the captured offset:
  - lb/lbu: byte offset*8.
  - lh/lhu: half at offset[1]*16.
  - lb/lh sign-extend; lbu/lhu zero-extend.
  - Load 101-111 are treated as lw.
- ReadData outside DONE = 0.

Decomposition:
- Package lsu_pkg:
  - Store/Load encoding constants (matching the decoder).
  - FSM state type {IDLE, REQ, DONE}.
  - Function for the alignment check.
- Sub-module load_extend: combinational extraction and extension (inputs rdata, Load code, offset; output 32-bit word).

Test Plan:
- sw Addr=0x104, WriteData=0xDEADBEEF, bus_ready on the 1st REQ cycle -> bus_addr=0x104, be=1111, wdata=0xDEADBEEF, we=1; Stall high 2 cycles; DONE after 3 cycles.
- sb Addr=0x203, WriteData=0x000000A5 -> be=1000, wdata=0xA5A5A5A5, bus_addr=0x200.
- lb Addr=0x301, rdata=0x12348000 with ready delayed 4 cycles -> ReadData=0xFFFFFF80 in DONE; Stall high for all 5 REQ cycles.
- lhu Addr=0x402, rdata=0x8001FFFF -> ReadData=0x00008001; same setup as lh -> ReadData=0xFFFF8001.
- lw Addr=0x102 -> Misaligned=1 for one cycle, bus_req never asserts, Stall=0.
- Timeout and reset:
  - TIMEOUT_CYCLES=4, bus_ready held 0 -> bus_req drops after 4 REQ cycles; DONE has BusErr=1, ReadData=0.
  - Separate run: reset asserted mid-REQ -> bus_req=0 asynchronously, FSM returns to IDLE.
